// File: rtl/opti_iir_pkg.sv
// Shared constants and enums for the time-multiplexed biquad cascade.
package opti_iir_pkg;

  localparam int NUM_SEC      = 5;
  localparam int TAPS_PER_SEC = 5;
  localparam int DW           = 16;
  localparam int ACC_W        = 36;
  localparam int FRAC         = 14;
  localparam int ROUND_C      = 1 << (FRAC - 1);
  localparam int SAT_MAX      = 32767;
  localparam int SAT_MIN      = -32768;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WB   = 2'd2,
    OUT  = 2'd3
  } iir_state_t;

  typedef enum logic [1:0] {
    ACC_HOLD = 2'd0,
    ACC_LOAD = 2'd1,
    ACC_ADD  = 2'd2,
    ACC_SUB  = 2'd3
  } acc_op_t;

endpackage

// File: rtl/opti_iir_mac.sv
// Shared multiply-accumulate: Q2.14 x Q1.15 products into a wide accumulator,
// with round-half-up back to Q1.15 and clamp detection.
module opti_iir_mac
  import opti_iir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  acc_op_t              op,
  input  logic signed [DW-1:0] coeff,
  input  logic signed [DW-1:0] operand,
  output logic signed [DW-1:0] y,
  output logic                 sat
);

  localparam int SW = ACC_W - FRAC;
  localparam logic signed [SW-1:0] HI = SW'(SAT_MAX);
  localparam logic signed [SW-1:0] LO = SW'(SAT_MIN);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] rounded;
  logic signed [SW-1:0]    shifted;
  logic                    sat_hi;
  logic                    sat_lo;

  assign prod     = coeff * operand;
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else begin
      case (op)
        ACC_LOAD: acc <= prod_ext;
        ACC_ADD:  acc <= acc + prod_ext;
        ACC_SUB:  acc <= acc - prod_ext;
        default:  acc <= acc;
      endcase
    end
  end

  // Dropping the low FRAC bits of the rounded sum is the arithmetic shift.
  assign rounded = acc + ACC_W'(ROUND_C);
  assign shifted = rounded[ACC_W-1:FRAC];
  assign sat_hi  = (shifted > HI);
  assign sat_lo  = (shifted < LO);
  assign sat     = sat_hi | sat_lo;

  always_comb begin
    y = shifted[DW-1:0];
    if (sat_hi) y = DW'(SAT_MAX);
    if (sat_lo) y = DW'(SAT_MIN);
  end

endmodule

// File: rtl/opti_iir_engine.sv
// Five-section biquad cascade sharing one MAC; one sample per 31-cycle frame.
// Owns the frame FSM, the per-section history and the output register.
module opti_iir_engine
  import opti_iir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic [4:0]           coeff_addr,
  input  logic signed [DW-1:0] coeff_data,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_data,
  output logic                 busy,
  output logic                 sat_flag,
  output iir_state_t           dbg_state
);

  localparam logic [2:0] LAST_SEC = 3'(NUM_SEC - 1);
  localparam logic [2:0] LAST_TAP = 3'(TAPS_PER_SEC - 1);

  iir_state_t state;
  iir_state_t state_nxt;

  logic [2:0]           sec;
  logic [2:0]           tap;
  logic [2:0]           sec_p1;
  logic signed [DW-1:0] sec_in;
  logic signed [DW-1:0] h [0:NUM_SEC][1:2];
  logic signed [DW-1:0] operand;
  acc_op_t              mac_op;
  logic signed [DW-1:0] y;
  logic                 y_sat;

  assign sec_p1    = sec + 3'd1;
  assign dbg_state = state;

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE with clr low, so there is no buffering.
  // out_valid is a single-cycle pulse with no backpressure.

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid && in_ready) state_nxt = MAC;
      MAC:  if (tap == LAST_TAP) state_nxt = WB;
      WB:   state_nxt = (sec == LAST_SEC) ? OUT : MAC;
      OUT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_comb begin
    in_ready   = (state == IDLE) && !clr;
    busy       = (state != IDLE);
    out_valid  = (state == OUT);
    coeff_addr = '0;
    if (state == MAC) coeff_addr = ({2'b00, sec} * 5'd5) + {2'b00, tap};
  end

  // Section k uses h[k] as its x history and h[k+1] as its y history.
  always_comb begin
    operand = sec_in;
    mac_op  = ACC_HOLD;
    if (state == MAC) begin
      case (tap)
        3'd0: begin operand = sec_in;      mac_op = ACC_LOAD; end
        3'd1: begin operand = h[sec][1];    mac_op = ACC_ADD;  end
        3'd2: begin operand = h[sec][2];    mac_op = ACC_ADD;  end
        3'd3: begin operand = h[sec_p1][1]; mac_op = ACC_SUB;  end
        3'd4: begin operand = h[sec_p1][2]; mac_op = ACC_SUB;  end
        default: begin operand = sec_in;   mac_op = ACC_HOLD; end
      endcase
    end
  end

  opti_iir_mac u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .op      (mac_op),
    .coeff   (coeff_data),
    .operand (operand),
    .y       (y),
    .sat     (y_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec      <= '0;
      tap      <= '0;
      sec_in   <= '0;
      out_data <= '0;
      sat_flag <= 1'b0;
      for (int i = 0; i <= NUM_SEC; i++) begin
        h[i][1] <= '0;
        h[i][2] <= '0;
      end
    end else if (clr) begin
      sec      <= '0;
      tap      <= '0;
      sat_flag <= 1'b0;
      for (int i = 0; i <= NUM_SEC; i++) begin
        h[i][1] <= '0;
        h[i][2] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sec_in <= in_data;
            sec    <= '0;
            tap    <= '0;
          end
        end
        MAC: tap <= (tap == LAST_TAP) ? 3'd0 : tap + 3'd1;
        WB: begin
          h[sec_p1][2] <= h[sec_p1][1];
          h[sec_p1][1] <= y;
          // The cascade input history is only advanced once per frame.
          if (sec == 3'd0) begin
            h[0][2] <= h[0][1];
            h[0][1] <= sec_in;
          end
          sec_in   <= y;
          sat_flag <= sat_flag | y_sat;
          tap      <= '0;
          if (sec != LAST_SEC) sec <= sec + 3'd1;
          else                 out_data <= y;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_opti_iir_engine.sv
// Directed bench for opti_iir_engine: queue-based scoreboard with an
// independent per-sample fixed-point model of the cascade.
module tb_opti_iir_engine;
  import opti_iir_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [4:0]  coeff_addr;
  logic [15:0] coeff_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        busy;
  logic        sat_flag;
  iir_state_t  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  // Bench ROM: every section b0=4321, b1=0, b2=-4321, a1=-1.5, a2=0.7 (Q2.14)
  int   coef_sec [0:4] = '{4321, 0, -4321, -24576, 11469};
  int   mc [0:24];
  logic [15:0] rom_real [0:24];
  logic rom_stub;
  int   mh [0:5][1:2];
  bit   model_sat;

  opti_iir_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .coeff_addr (coeff_addr),
    .coeff_data (coeff_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy),
    .sat_flag   (sat_flag),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 25; i++) begin
      mc[i]       = coef_sec[i % 5];
      rom_real[i] = 16'(mc[i]);
    end
  end

  always_comb begin
    coeff_data = 16'h0000;
    if (rom_stub) coeff_data = (coeff_addr % 5 == 0) ? 16'h7FFF : 16'h0000;
    else if (coeff_addr <= 5'd24) coeff_data = rom_real[coeff_addr];
  end

  // model
  function automatic void model_reset();
    for (int i = 0; i <= 5; i++) begin
      mh[i][1] = 0;
      mh[i][2] = 0;
    end
    model_sat = 1'b0;
  endfunction

  function automatic logic [15:0] model_step(input logic [15:0] xin);
    int     x;
    int     yv;
    longint acc;
    x = int'($signed(xin));
    for (int k = 0; k < 5; k++) begin
      acc = longint'(mc[5*k]) * x + longint'(mc[5*k+1]) * mh[k][1]
          + longint'(mc[5*k+2]) * mh[k][2] - longint'(mc[5*k+3]) * mh[k+1][1]
          - longint'(mc[5*k+4]) * mh[k+1][2];
      acc = (acc + 8192) >>> 14;
      if (acc > 32767) begin acc = 32767; model_sat = 1'b1; end
      if (acc < -32768) begin acc = -32768; model_sat = 1'b1; end
      yv = int'(acc);
      if (k == 0) begin
        mh[0][2] = mh[0][1];
        mh[0][1] = x;
      end
      mh[k+1][2] = mh[k+1][1];
      mh[k+1][1] = yv;
      x = yv;
    end
    return 16'(x);
  endfunction

  // checking helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out_valid: got data 0x%0h expected no output at %0t",
                 out_data, $time);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic send_sample(input logic [15:0] d, input bit push, input logic [15:0] e);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      note_fail("accept_timeout");
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      note_fail("frame_timeout");
      exp_q.delete();
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
    chk({tag, "_out_valid"},  32'(out_valid),  32'd0);
    chk({tag, "_out_data"},   32'(out_data),   32'd0);
    chk({tag, "_coeff_addr"}, 32'(coeff_addr), 32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_sat_flag"},   32'(sat_flag),   32'd0);
    chk({tag, "_state"},      32'(dbg_state),  32'(IDLE));
  endtask

  // stimulus
  initial begin
    logic [15:0] e2;
    logic [4:0]  ea;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; rom_stub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset");

    // impulse with address trace; a zero sample is held valid across the frame
    model_reset();
    void'(model_step(16'h4000));
    e2 = model_step(16'h0000);
    send_sample(16'h4000, 1'b1, 16'h0015);
    in_valid = 1'b1;
    in_data  = 16'h0000;
    exp_q.push_back(e2);
    for (int cyc = 0; cyc <= 32; cyc++) begin
      @(negedge clk);
      if (cyc < 30) begin
        ea = (cyc % 6 == 5) ? 5'd0 : 5'((cyc / 6) * 5 + (cyc % 6));
        chk($sformatf("trace_addr_c%0d", cyc), 32'(coeff_addr), 32'(ea));
        chk($sformatf("trace_ready_c%0d", cyc), 32'(in_ready), 32'd0);
        chk($sformatf("trace_busy_c%0d", cyc), 32'(busy), 32'd1);
        chk($sformatf("trace_valid_c%0d", cyc), 32'(out_valid), 32'd0);
      end else if (cyc == 30) begin
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        chk("latency_in_ready", 32'(in_ready), 32'd0);
      end else if (cyc == 31) begin
        chk("post_out_in_ready", 32'(in_ready), 32'd1);
        chk("post_out_busy", 32'(busy), 32'd0);
        chk("post_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
      end else begin
        chk("second_accept_busy", 32'(busy), 32'd1);
        chk("second_accept_ready", 32'(in_ready), 32'd0);
      end
    end
    wait_idle();

    // zero stream, then impulse response against the model
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 64; i++) send_sample(16'h0000, 1'b1, 16'h0000);
    wait_idle();
    chk("zero_stream_sat", 32'(sat_flag), 32'd0);
    model_reset();
    send_sample(16'h4000, 1'b1, model_step(16'h4000));
    for (int i = 0; i < 200; i++) send_sample(16'h0000, 1'b1, model_step(16'h0000));
    wait_idle();
    chk("impulse_stream_sat", 32'(sat_flag), 32'(model_sat));

    // saturation with the stub ROM
    rom_stub = 1'b1;
    send_sample(16'h7FFF, 1'b1, 16'h7FFF);
    wait_idle();
    chk("stub_pos_sat", 32'(sat_flag), 32'd1);
    send_sample(16'h8000, 1'b1, 16'h8000);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("stub_sat_sticky", 32'(sat_flag), 32'd1);
    rom_stub = 1'b0;

    // asynchronous reset between edges mid-frame
    send_sample(16'h4000, 1'b0, 16'h0000);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    @(negedge clk) rst_n = 1'b1;
    send_sample(16'h4000, 1'b1, 16'h0015);
    wait_idle();

    // clr at frame cycle 12 aborts the frame and zeroes history
    send_sample(16'h4000, 1'b0, 16'h0000);
    repeat (12) @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    chk("clr_busy", 32'(busy), 32'd0);
    repeat (35) @(negedge clk);
    send_sample(16'h4000, 1'b1, 16'h0015);
    wait_idle();

    // clr coinciding with a valid sample: the sample is dropped
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_data = 16'h4000;
    #1 chk("clr_forces_not_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("clr_drops_sample", 32'(busy), 32'd0);
    clr = 1'b0; in_valid = 1'b0;
    repeat (35) @(negedge clk);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
